multi_vnet_input_port: RTL and testbench
========================================

MULTI_VNET_INPUT_PORT -- requirements
Module: multi_vnet_input_port

Interface
REQ-001 SHALL have parameter N_VNET, default 3: number of virtual networks.
REQ-002 SHALL have parameter N_VC_PER_VNET, default 2: VCs per vnet; N_VC = N_VNET*N_VC_PER_VNET.
REQ-003 SHALL have parameter MAX_PKT_LEN, default 4: flit slots per VC buffer.
REQ-004 SHALL have parameter FLIT_WIDTH, default `FLIT_WIDTH: flit bits.
REQ-005 SHALL have: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have: flit_i  in  FLIT_WIDTH  flit from router, with type/vnet/vc fields at the positions set by the shared package.
REQ-007 SHALL have: flit_valid_i  in  1  flit_i valid this cycle.
REQ-008 SHALL have: credit_o  out  N_VC  one-cycle pulse per freed flit slot.
REQ-009 SHALL have: free_o  out  N_VC  one-cycle pulse when a VC returns to IDLE.
REQ-010 SHALL have: pkt_req_o  out  1, pkt_gnt_i  in  1  packet handshake.
REQ-011 SHALL have: pkt_o  out  MAX_PKT_LEN*FLIT_WIDTH  packet, head at bit 0.
REQ-012 SHALL have: pkt_len_o  out  clog2(MAX_PKT_LEN+1)  and  pkt_vc_o  out  clog2(N_VC)  flit count and source VC.

Function
REQ-013 Target VC index SHALL be vnet*N_VC_PER_VNET+vc; out-of-range index drops the flit.
REQ-014 Each VC SHALL run FSM IDLE, COLLECT, READY, DRAIN.
REQ-015 IDLE: head accepted -> COLLECT; head_tail accepted -> READY; flit stored at slot 0, count=1.
REQ-016 COLLECT: body stored at slot count, count+1; tail stored -> READY next cycle.
REQ-017 Accepted tail at cycle N SHALL make the VC eligible for pkt_req_o at N+1.
REQ-018 Arbiter SHALL select combinationally the first READY VC at or after registered pointer rr_ptr, wrapping N_VC-1 -> 0.
REQ-019 pkt_req_o SHALL be high iff any VC is READY; pkt_o/pkt_len_o/pkt_vc_o SHALL reflect the selected VC and be stable while pkt_req_o is high and pkt_gnt_i low.
REQ-020 pkt_req_o AND pkt_gnt_i SHALL complete transfer: selected VC -> DRAIN, rr_ptr <= selected+1 (wrapping).
REQ-021 pkt_gnt_i without pkt_req_o SHALL be ignored.
REQ-022 DRAIN SHALL pulse credit_o[i] on each of count consecutive cycles, then enter IDLE with free_o[i] pulsing the same cycle as the last credit.
REQ-023 Slots beyond pkt_len_o SHALL read as zero.
REQ-024 Flit to a VC in READY/DRAIN, or a flit beyond MAX_PKT_LEN, SHALL be dropped without state change.
REQ-025 Flit arrival and grant on different VCs in the same cycle SHALL both take effect.

Reset
REQ-026 rst SHALL put all VCs in IDLE, count=0, rr_ptr=0, buffers zero.
REQ-027 rst SHALL drive credit_o=0, free_o=0, pkt_req_o=0, pkt_o=0, pkt_len_o=0, pkt_vc_o=0; rst mid-packet or mid-DRAIN discards without credit or free pulses.

Configuration
REQ-028 With INPUT_PORT_ERR_EN defined, port err_o (out, N_VC) SHALL be present and set sticky on: body/tail to IDLE VC, head to COLLECT VC, any REQ-024 drop; cleared only by rst.
REQ-029 Without INPUT_PORT_ERR_EN, err_o SHALL be absent and drops SHALL be silent.

Structure
REQ-030 Flit type encodings, field bit ranges and VC FSM state typedef SHALL live in shared package nic_pkg.
REQ-031 Per-VC storage and FSM SHALL be sub-module vc_pkt_buffer, instantiated N_VC times; arbiter and muxing SHALL stay in the top.

Verification
REQ-032 head,body,tail to vnet1 vc0 (VC2), gnt held high -> pkt_req_o at cycle after tail, pkt_len_o=3, pkt_vc_o=2, then 3 credit_o[2] pulses, free_o[2] with the third.
REQ-033 head_tail to VC0, VC3, VC5 together READY, rr_ptr=0, gnt always high -> grant order 0,3,5, rr_ptr ends 0.
REQ-034 READY VC1 with gnt low 5 cycles -> pkt_o stable, no credit pulses; gnt high cycle 6 -> DRAIN.
REQ-035 5 flits to one VC, MAX_PKT_LEN=4 -> 5th dropped; err_o set when INPUT_PORT_ERR_EN defined.
REQ-036 rst asserted during DRAIN after 1 of 3 credits -> no further credit/free pulses, all outputs 0 next cycle.

Source files
------------

// File: rtl/multi_vnet_input_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nic_pkg
// Description : Shared flit field layout, flit type encodings and VC FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

package nic_pkg;

  localparam int c_type_lsb = 0;
  localparam int c_type_w   = 2;
  localparam int c_vnet_lsb = 2;
  localparam int c_vnet_w   = 2;
  localparam int c_vc_lsb   = 4;
  localparam int c_vc_w     = 2;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    VC_IDLE    = 2'd0,
    VC_COLLECT = 2'd1,
    VC_READY   = 2'd2,
    VC_DRAIN   = 2'd3
  } vc_state_e;

endpackage

`default_nettype wire

// File: rtl/multi_vnet_input_port_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_vnet_input_port_if
// Description : Flit ingress, credit/free return and packet handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

interface multi_vnet_input_port_if #(
  parameter int N_VNET        = 3,
  parameter int N_VC_PER_VNET = 2,
  parameter int MAX_PKT_LEN   = 4,
  parameter int FLIT_WIDTH    = `FLIT_WIDTH
);
  localparam int N_VC     = N_VNET * N_VC_PER_VNET;
  localparam int VC_IDX_W = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int LEN_W    = $clog2(MAX_PKT_LEN + 1);

  logic [FLIT_WIDTH-1:0]             flit_i;
  logic                              flit_valid_i;
  logic [N_VC-1:0]                   credit_o;
  logic [N_VC-1:0]                   free_o;
  logic                              pkt_req_o;
  logic                              pkt_gnt_i;
  logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] pkt_o;
  logic [LEN_W-1:0]                  pkt_len_o;
  logic [VC_IDX_W-1:0]               pkt_vc_o;

  modport slave (
    input  flit_i, flit_valid_i, pkt_gnt_i,
    output credit_o, free_o, pkt_req_o, pkt_o, pkt_len_o, pkt_vc_o
  );

  modport master (
    output flit_i, flit_valid_i, pkt_gnt_i,
    input  credit_o, free_o, pkt_req_o, pkt_o, pkt_len_o, pkt_vc_o
  );

endinterface

`default_nettype wire

// File: rtl/multi_vnet_input_port_vc_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vc_pkt_buffer
// Description : One VC's packet slots and IDLE/COLLECT/READY/DRAIN FSM.
//               INPUT_PORT_ERR_EN adds a sticky protocol/drop error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_pkt_buffer
  import nic_pkg::*;
#(
  parameter int MAX_PKT_LEN = 4,
  parameter int FLIT_WIDTH  = 32,
  parameter int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  wire logic                              clk,
  input  wire logic                              rst,
  input  wire logic                              wr_en_i,
  input  wire logic [FLIT_WIDTH-1:0]             flit_i,
  input  wire logic                              gnt_i,
  output logic                                   ready_o,
  output logic                                   credit_o,
  output logic                                   free_o,
  output logic [MAX_PKT_LEN*FLIT_WIDTH-1:0]      pkt_o,
  output logic [LEN_W-1:0]                       len_o
`ifdef INPUT_PORT_ERR_EN
  ,
  output logic                                   err_o
`endif
);

  vc_state_e             state_q, state_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic [LEN_W-1:0]      remain_q, remain_d;
  logic [FLIT_WIDTH-1:0] slot_q [MAX_PKT_LEN];
  logic [FLIT_WIDTH-1:0] slot_d [MAX_PKT_LEN];
  flit_type_e            ftype;
  logic                  is_head;
  logic                  room;

  assign ftype   = flit_type_e'(flit_i[c_type_lsb +: c_type_w]);
  assign is_head = (ftype == FLIT_HEAD) || (ftype == FLIT_HEAD_TAIL);
  assign room    = (count_q < LEN_W'(MAX_PKT_LEN));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    remain_d = remain_q;
    slot_d   = slot_q;
    case (state_q)
      VC_IDLE: begin
        if (wr_en_i && is_head) begin
          slot_d[0] = flit_i;
          count_d   = LEN_W'(1);
          state_d   = (ftype == FLIT_HEAD_TAIL) ? VC_READY : VC_COLLECT;
        end
      end
      VC_COLLECT: begin
        if (wr_en_i && !is_head && room) begin
          for (int s = 0; s < MAX_PKT_LEN; s++) begin
            if (count_q == LEN_W'(s)) slot_d[s] = flit_i;
          end
          count_d = count_q + LEN_W'(1);
          if (ftype == FLIT_TAIL) state_d = VC_READY;
        end
      end
      VC_READY: begin
        if (gnt_i) begin
          state_d  = VC_DRAIN;
          remain_d = count_q;
        end
      end
      VC_DRAIN: begin
        remain_d = remain_q - LEN_W'(1);
        // Slots are cleared on exit so unused slots of the next packet read zero.
        if (remain_q == LEN_W'(1)) begin
          state_d = VC_IDLE;
          count_d = '0;
          for (int s = 0; s < MAX_PKT_LEN; s++) slot_d[s] = '0;
        end
      end
      default: state_d = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= VC_IDLE;
      count_q  <= '0;
      remain_q <= '0;
      for (int s = 0; s < MAX_PKT_LEN; s++) slot_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      slot_q   <= slot_d;
    end
  end

  assign ready_o  = (state_q == VC_READY);
  assign credit_o = (state_q == VC_DRAIN);
  assign free_o   = (state_q == VC_DRAIN) && (remain_q == LEN_W'(1));
  assign len_o    = count_q;

  for (genvar s = 0; s < MAX_PKT_LEN; s++) begin : g_flat
    assign pkt_o[s*FLIT_WIDTH +: FLIT_WIDTH] = slot_q[s];
  end

`ifdef INPUT_PORT_ERR_EN
  logic err_evt;
  logic err_q, err_d;

  always_comb begin
    err_evt = 1'b0;
    if (wr_en_i) begin
      case (state_q)
        VC_IDLE:    err_evt = !is_head;
        VC_COLLECT: err_evt = is_head || !room;
        default:    err_evt = 1'b1;
      endcase
    end
    err_d = err_q | err_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

`default_nettype wire

// File: rtl/multi_vnet_input_port.sv
`default_nettype none
// ============================================================================
// Module      : multi_vnet_input_port
// Description : Multi-vnet NIC input port: per-VC packet assembly, round-robin
//               packet arbitration. INPUT_PORT_ERR_EN adds sticky err_o.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module multi_vnet_input_port
  import nic_pkg::*;
#(
  parameter int N_VNET        = 3,
  parameter int N_VC_PER_VNET = 2,
  parameter int MAX_PKT_LEN   = 4,
  parameter int FLIT_WIDTH    = `FLIT_WIDTH,
  localparam int N_VC         = N_VNET * N_VC_PER_VNET
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  multi_vnet_input_port_if.slave    bus
`ifdef INPUT_PORT_ERR_EN
  ,
  output logic [N_VC-1:0]           err_o
`endif
);

  localparam int VC_IDX_W = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int LEN_W    = $clog2(MAX_PKT_LEN + 1);
  localparam int PKT_W    = MAX_PKT_LEN * FLIT_WIDTH;

  logic [c_vnet_w-1:0] f_vnet;
  logic [c_vc_w-1:0]   f_vc;
  logic [7:0]          tgt;
  logic [N_VC-1:0]     wr_en;
  logic [N_VC-1:0]     ready;
  logic [N_VC-1:0]     credit_raw;
  logic [N_VC-1:0]     free_raw;
  logic [PKT_W-1:0]    pkt_arr [N_VC];
  logic [LEN_W-1:0]    len_arr [N_VC];

  logic                sel_valid;
  logic [VC_IDX_W-1:0] sel_idx;
  logic                xfer;
  logic [VC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  assign f_vnet = bus.flit_i[c_vnet_lsb +: c_vnet_w];
  assign f_vc   = bus.flit_i[c_vc_lsb +: c_vc_w];
  // Indices at or above N_VC match no VC, so such flits are simply dropped.
  assign tgt    = 8'(f_vnet) * 8'(N_VC_PER_VNET) + 8'(f_vc);

  for (genvar i = 0; i < N_VC; i++) begin : g_vc
    assign wr_en[i] = bus.flit_valid_i && (tgt == 8'(i));

    vc_pkt_buffer #(
      .MAX_PKT_LEN (MAX_PKT_LEN),
      .FLIT_WIDTH  (FLIT_WIDTH),
      .LEN_W       (LEN_W)
    ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en[i]),
      .flit_i   (bus.flit_i),
      .gnt_i    (xfer && (sel_idx == VC_IDX_W'(i))),
      .ready_o  (ready[i]),
      .credit_o (credit_raw[i]),
      .free_o   (free_raw[i]),
      .pkt_o    (pkt_arr[i]),
      .len_o    (len_arr[i])
`ifdef INPUT_PORT_ERR_EN
      ,
      .err_o    (err_o[i])
`endif
    );
  end

  // First pass finds the lowest READY VC (wrap case); second pass overrides it
  // with the lowest READY VC at or after rr_ptr when one exists.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int j = N_VC - 1; j >= 0; j--) begin
      if (ready[j]) begin
        sel_valid = 1'b1;
        sel_idx   = VC_IDX_W'(j);
      end
    end
    for (int j = N_VC - 1; j >= 0; j--) begin
      if (ready[j] && (VC_IDX_W'(j) >= rr_ptr_q)) sel_idx = VC_IDX_W'(j);
    end
  end

  assign xfer = sel_valid && bus.pkt_gnt_i;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (sel_idx == VC_IDX_W'(N_VC - 1)) ? '0 : sel_idx + VC_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign bus.pkt_req_o = sel_valid && !rst;
  assign bus.pkt_o     = bus.pkt_req_o ? pkt_arr[sel_idx] : '0;
  assign bus.pkt_len_o = bus.pkt_req_o ? len_arr[sel_idx] : '0;
  assign bus.pkt_vc_o  = bus.pkt_req_o ? sel_idx : '0;
  assign bus.credit_o  = rst ? '0 : credit_raw;
  assign bus.free_o    = rst ? '0 : free_raw;

endmodule

`default_nettype wire

// File: tb/tb_multi_vnet_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_vnet_input_port
// Description : Directed self-checking bench for multi_vnet_input_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_vnet_input_port;
  import nic_pkg::*;

  localparam int FW = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [5:0] err;

  multi_vnet_input_port_if #(.FLIT_WIDTH(FW)) bus ();

  multi_vnet_input_port #(.FLIT_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef INPUT_PORT_ERR_EN
    ,
    .err_o (err)
`endif
  );

`ifndef INPUT_PORT_ERR_EN
  assign err = 6'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] vn,
                                       input logic [1:0] vc, input logic [25:0] pl);
    return {pl, vc, vn, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f);
    bus.flit_i       = f;
    bus.flit_valid_i = 1'b1;
    step();
    bus.flit_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flit_i = '0;
    bus.flit_valid_i = 1'b0;
    bus.pkt_gnt_i = 1'b0;
    step();
    step();
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bus.pkt_req_o); end
    total++; if (bus.credit_o !== 6'b0) begin bad++; $display("FAIL rst_credit got=%b want=0", bus.credit_o); end
    total++; if (bus.free_o !== 6'b0) begin bad++; $display("FAIL rst_free got=%b want=0", bus.free_o); end
    total++; if (bus.pkt_o !== 128'b0) begin bad++; $display("FAIL rst_pkt got=%h want=0", bus.pkt_o); end
    total++; if (bus.pkt_len_o !== 3'd0) begin bad++; $display("FAIL rst_len got=%0d want=0", bus.pkt_len_o); end
    total++; if (bus.pkt_vc_o !== 3'd0) begin bad++; $display("FAIL rst_vc got=%0d want=0", bus.pkt_vc_o); end
    total++; if (err !== 6'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    rst = 1'b0;
    step();
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL idle_req got=%b want=0", bus.pkt_req_o); end
  endtask

  task automatic test_single();
    logic [FW-1:0] a, b, c;
    a = mk(FLIT_HEAD, 2'd1, 2'd0, 26'h0AAAA1);
    b = mk(FLIT_BODY, 2'd1, 2'd0, 26'h0BBBB2);
    c = mk(FLIT_TAIL, 2'd1, 2'd0, 26'h0CCCC3);
    bus.pkt_gnt_i = 1'b1;
    send(a);
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL single_collect_req got=%b want=0", bus.pkt_req_o); end
    send(b);
    send(c);
    total++; if (bus.pkt_req_o !== 1'b1) begin bad++; $display("FAIL single_req got=%b want=1", bus.pkt_req_o); end
    total++; if (bus.pkt_len_o !== 3'd3) begin bad++; $display("FAIL single_len got=%0d want=3", bus.pkt_len_o); end
    total++; if (bus.pkt_vc_o !== 3'd2) begin bad++; $display("FAIL single_vc got=%0d want=2", bus.pkt_vc_o); end
    total++; if (bus.pkt_o !== {32'h0, c, b, a}) begin bad++; $display("FAIL single_pkt got=%h want=%h", bus.pkt_o, {32'h0, c, b, a}); end
    total++; if (bus.credit_o !== 6'b0) begin bad++; $display("FAIL single_early_credit got=%b want=0", bus.credit_o); end
    step();
    total++; if (bus.credit_o !== 6'b000100) begin bad++; $display("FAIL single_credit1 got=%b want=000100", bus.credit_o); end
    total++; if (bus.free_o !== 6'b0) begin bad++; $display("FAIL single_free1 got=%b want=0", bus.free_o); end
    step();
    total++; if (bus.credit_o !== 6'b000100) begin bad++; $display("FAIL single_credit2 got=%b want=000100", bus.credit_o); end
    total++; if (bus.free_o !== 6'b0) begin bad++; $display("FAIL single_free2 got=%b want=0", bus.free_o); end
    step();
    total++; if (bus.credit_o !== 6'b000100) begin bad++; $display("FAIL single_credit3 got=%b want=000100", bus.credit_o); end
    total++; if (bus.free_o !== 6'b000100) begin bad++; $display("FAIL single_free3 got=%b want=000100", bus.free_o); end
    step();
    total++; if (bus.credit_o !== 6'b0) begin bad++; $display("FAIL single_credit_end got=%b want=0", bus.credit_o); end
    total++; if (bus.free_o !== 6'b0) begin bad++; $display("FAIL single_free_end got=%b want=0", bus.free_o); end
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL single_req_end got=%b want=0", bus.pkt_req_o); end
    bus.pkt_gnt_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_vc [3];
    exp_vc[0] = 3'd0; exp_vc[1] = 3'd3; exp_vc[2] = 3'd5;
    do_reset();
    bus.pkt_gnt_i = 1'b0;
    send(mk(FLIT_HEAD_TAIL, 2'd0, 2'd0, 26'h000010));
    send(mk(FLIT_HEAD_TAIL, 2'd1, 2'd1, 26'h000013));
    send(mk(FLIT_HEAD_TAIL, 2'd2, 2'd1, 26'h000015));
    total++; if (bus.pkt_req_o !== 1'b1) begin bad++; $display("FAIL rr_req got=%b want=1", bus.pkt_req_o); end
    bus.pkt_gnt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.pkt_vc_o !== exp_vc[k]) begin bad++; $display("FAIL rr_order%0d got=%0d want=%0d", k, bus.pkt_vc_o, exp_vc[k]); end
      total++; if (bus.pkt_len_o !== 3'd1) begin bad++; $display("FAIL rr_len%0d got=%0d want=1", k, bus.pkt_len_o); end
      step();
    end
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL rr_req_end got=%b want=0", bus.pkt_req_o); end
    total++; if (dut.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL rr_ptr_end got=%0d want=0", dut.rr_ptr_q); end
    bus.pkt_gnt_i = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [FW-1:0] d, f;
    d = mk(FLIT_HEAD_TAIL, 2'd0, 2'd1, 26'h0DDDD4);
    f = mk(FLIT_HEAD_TAIL, 2'd0, 2'd0, 26'h0FFFF5);
    bus.pkt_gnt_i = 1'b0;
    send(d);
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.pkt_o !== {96'h0, d}) begin bad++; $display("FAIL stall_pkt%0d got=%h want=%h", k, bus.pkt_o, {96'h0, d}); end
      total++; if (bus.credit_o !== 6'b0) begin bad++; $display("FAIL stall_credit%0d got=%b want=0", k, bus.credit_o); end
      total++; if (bus.pkt_vc_o !== 3'd1) begin bad++; $display("FAIL stall_vc%0d got=%0d want=1", k, bus.pkt_vc_o); end
      step();
    end
    bus.pkt_gnt_i = 1'b1;
    send(f);
    bus.pkt_gnt_i = 1'b0;
    total++; if (bus.credit_o !== 6'b000010) begin bad++; $display("FAIL stall_drain_credit got=%b want=000010", bus.credit_o); end
    total++; if (bus.free_o !== 6'b000010) begin bad++; $display("FAIL stall_drain_free got=%b want=000010", bus.free_o); end
    total++; if (bus.pkt_req_o !== 1'b1) begin bad++; $display("FAIL same_cycle_req got=%b want=1", bus.pkt_req_o); end
    total++; if (bus.pkt_vc_o !== 3'd0) begin bad++; $display("FAIL same_cycle_vc got=%0d want=0", bus.pkt_vc_o); end
  endtask

  task automatic test_drop();
    logic [FW-1:0] f;
    f = mk(FLIT_HEAD_TAIL, 2'd0, 2'd0, 26'h0FFFF5);
    send(mk(FLIT_HEAD_TAIL, 2'd0, 2'd0, 26'h012345));
    send(mk(FLIT_HEAD, 2'd3, 2'd0, 26'h054321));
    total++; if (bus.pkt_len_o !== 3'd1) begin bad++; $display("FAIL drop_len got=%0d want=1", bus.pkt_len_o); end
    total++; if (bus.pkt_o !== {96'h0, f}) begin bad++; $display("FAIL drop_pkt got=%h want=%h", bus.pkt_o, {96'h0, f}); end
`ifdef INPUT_PORT_ERR_EN
    total++; if (err !== 6'b000001) begin bad++; $display("FAIL drop_err got=%b want=000001", err); end
`endif
    bus.pkt_gnt_i = 1'b1;
    step();
    bus.pkt_gnt_i = 1'b0;
    total++; if (bus.free_o !== 6'b000001) begin bad++; $display("FAIL drop_free got=%b want=000001", bus.free_o); end
    step();
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL drop_req_end got=%b want=0", bus.pkt_req_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.pkt_gnt_i = 1'b0;
    send(mk(FLIT_HEAD, 2'd2, 2'd0, 26'h000001));
    send(mk(FLIT_BODY, 2'd2, 2'd0, 26'h000002));
    send(mk(FLIT_BODY, 2'd2, 2'd0, 26'h000003));
    send(mk(FLIT_BODY, 2'd2, 2'd0, 26'h000004));
`ifdef INPUT_PORT_ERR_EN
    total++; if (err !== 6'b0) begin bad++; $display("FAIL ovf_err_early got=%b want=0", err); end
`endif
    send(mk(FLIT_TAIL, 2'd2, 2'd0, 26'h000005));
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL ovf_req got=%b want=0", bus.pkt_req_o); end
`ifdef INPUT_PORT_ERR_EN
    total++; if (err !== 6'b010000) begin bad++; $display("FAIL ovf_err got=%b want=010000", err); end
`endif
  endtask

  task automatic test_reset_drain();
    do_reset();
    bus.pkt_gnt_i = 1'b1;
    send(mk(FLIT_HEAD, 2'd1, 2'd0, 26'h000021));
    send(mk(FLIT_BODY, 2'd1, 2'd0, 26'h000022));
    send(mk(FLIT_TAIL, 2'd1, 2'd0, 26'h000023));
    total++; if (bus.pkt_req_o !== 1'b1) begin bad++; $display("FAIL rd_req got=%b want=1", bus.pkt_req_o); end
    step();
    total++; if (bus.credit_o !== 6'b000100) begin bad++; $display("FAIL rd_credit1 got=%b want=000100", bus.credit_o); end
    step();
    rst = 1'b1;
    #1;
    total++; if (bus.credit_o !== 6'b0) begin bad++; $display("FAIL rd_credit_in_rst got=%b want=0", bus.credit_o); end
    step();
    rst = 1'b0;
    #1;
    total++; if (bus.pkt_req_o !== 1'b0) begin bad++; $display("FAIL rd_req_after got=%b want=0", bus.pkt_req_o); end
    total++; if (bus.pkt_o !== 128'b0) begin bad++; $display("FAIL rd_pkt_after got=%h want=0", bus.pkt_o); end
    total++; if (bus.pkt_len_o !== 3'd0) begin bad++; $display("FAIL rd_len_after got=%0d want=0", bus.pkt_len_o); end
    total++; if (bus.pkt_vc_o !== 3'd0) begin bad++; $display("FAIL rd_vc_after got=%0d want=0", bus.pkt_vc_o); end
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.credit_o !== 6'b0) begin bad++; $display("FAIL rd_credit_post%0d got=%b want=0", k, bus.credit_o); end
      total++; if (bus.free_o !== 6'b0) begin bad++; $display("FAIL rd_free_post%0d got=%b want=0", k, bus.free_o); end
      step();
    end
    bus.pkt_gnt_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.flit_i       = '0;
    bus.flit_valid_i = 1'b0;
    bus.pkt_gnt_i    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_overflow();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
